// File: rtl/ups_axil_regs.sv
// ups_axil_regs
//   AXI4-Lite responder holding a small 32-bit register bank behind the PS
//   ca4l_* master port.
//   Map (addr[4:2]): 0 ID | 1 CTRL | 2 STATUS | 3 SCRATCH | 4 IRQ_PEND (W1C) |
//   5 IRQ_EN | 6 TICK | 7 reserved. Any address with addr[31:5] != 0 gets SLVERR.
// Ports
//   fclk, rst_n            clock, async active-low reset
//   ca4l_aw*/w*/b*         write address / data / response channels
//   ca4l_ar*/r*            read address / data channels
//   status                 status word returned by the STATUS register
//   evt                    single-cycle event pulses that set IRQ_PEND bits
//   ctrl                   CTRL register contents
//   irq                    registered |(IRQ_PEND & IRQ_EN)
module ups_axil_regs #(
    parameter logic [31:0] ID_VALUE = 32'h5550_5301,
    parameter int          CTRL_W   = 4,
    parameter int          EVT_W    = 8
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic [31:0]       ca4l_awaddr,
    input  logic [2:0]        ca4l_awprot,
    input  logic              ca4l_awvalid,
    output logic              ca4l_awready,
    input  logic [31:0]       ca4l_wdata,
    input  logic [3:0]        ca4l_wstrb,
    input  logic              ca4l_wvalid,
    output logic              ca4l_wready,
    output logic [1:0]        ca4l_bresp,
    output logic              ca4l_bvalid,
    input  logic              ca4l_bready,
    input  logic [31:0]       ca4l_araddr,
    input  logic [2:0]        ca4l_arprot,
    input  logic              ca4l_arvalid,
    output logic              ca4l_arready,
    output logic [31:0]       ca4l_rdata,
    output logic [1:0]        ca4l_rresp,
    output logic              ca4l_rvalid,
    input  logic              ca4l_rready,
    input  logic [31:0]       status,
    input  logic [EVT_W-1:0]  evt,
    output logic [CTRL_W-1:0] ctrl,
    output logic              irq
);

    typedef enum logic [2:0] {
        REG_ID, REG_CTRL, REG_STATUS, REG_SCRATCH,
        REG_IRQ_PEND, REG_IRQ_EN, REG_TICK, REG_RSVD
    } reg_sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Architectural registers
    logic [CTRL_W-1:0] r_ctrl;
    logic [31:0]       r_scratch;
    logic [EVT_W-1:0]  r_irq_pend;
    logic [EVT_W-1:0]  r_irq_en;
    logic [31:0]       r_tick;
    logic              r_irq;

    // Write channel state
    logic        r_aw_held, r_w_held;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awready, r_wready, r_bvalid;
    logic [1:0]  r_bresp;

    // Read channel state
    logic        r_arready, r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    // ---------------- write path ----------------
    logic        w_aw_hs, w_w_hs, w_b_done, w_wr_go, w_wr_err;
    logic [31:0] w_wr_addr, w_wr_data, w_wr_mask, w_wr_old, w_wr_merged, w_wr_clr;
    logic [3:0]  w_wr_strb;
    reg_sel_e    w_wr_sel;
    logic        w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt;
    logic [EVT_W-1:0] w_pend_clr;

    assign w_aw_hs  = ca4l_awvalid && r_awready;
    assign w_w_hs   = ca4l_wvalid && r_wready;
    assign w_b_done = r_bvalid && ca4l_bready;

    // A write commits on the edge where both halves are present, whether each
    // was captured earlier or is handshaking right now.
    assign w_wr_go   = !r_bvalid && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_addr = r_aw_held ? r_awaddr : ca4l_awaddr;
    assign w_wr_data = r_w_held  ? r_wdata  : ca4l_wdata;
    assign w_wr_strb = r_w_held  ? r_wstrb  : ca4l_wstrb;
    assign w_wr_err  = |w_wr_addr[31:5];
    assign w_wr_sel  = reg_sel_e'(w_wr_addr[4:2]);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_wr_mask[8*i +: 8] = {8{w_wr_strb[i]}};
        end
    end

    // NOTE: every variable driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_wr_old = '0;
        case (w_wr_sel)
            REG_CTRL:    w_wr_old = 32'(r_ctrl);
            REG_SCRATCH: w_wr_old = r_scratch;
            REG_IRQ_EN:  w_wr_old = 32'(r_irq_en);
            default:     w_wr_old = '0;
        endcase
    end

    assign w_wr_merged = (w_wr_old & ~w_wr_mask) | (w_wr_data & w_wr_mask);
    assign w_wr_clr    = w_wr_data & w_wr_mask;
    assign w_pend_clr  = (w_wr_go && !w_wr_err && w_wr_sel == REG_IRQ_PEND)
                         ? w_wr_clr[EVT_W-1:0] : '0;

    // Held flags stay set through the response so the readies remain low
    // until the master takes bvalid.
    assign w_aw_held_nxt = !w_b_done && (r_aw_held || w_aw_hs);
    assign w_w_held_nxt  = !w_b_done && (r_w_held || w_w_hs);
    assign w_bvalid_nxt  = r_bvalid ? !ca4l_bready : w_wr_go;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) r_awaddr <= ca4l_awaddr;
            if (w_w_hs) begin
                r_wdata <= ca4l_wdata;
                r_wstrb <= ca4l_wstrb;
            end
            if (w_wr_go) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
            r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
        end
    end

    // ---------------- register bank ----------------
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_scratch  <= '0;
            r_irq_en   <= '0;
            r_irq_pend <= '0;
            r_tick     <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_go && !w_wr_err) begin
                case (w_wr_sel)
                    REG_CTRL:    r_ctrl    <= w_wr_merged[CTRL_W-1:0];
                    REG_SCRATCH: r_scratch <= w_wr_merged;
                    REG_IRQ_EN:  r_irq_en  <= w_wr_merged[EVT_W-1:0];
                    default:     ;
                endcase
            end
            // OR-ing events after the clear makes a coincident set win.
            r_irq_pend <= (r_irq_pend & ~w_pend_clr) | evt;
            r_tick     <= r_tick + 32'd1;
            r_irq      <= |(r_irq_pend & r_irq_en);
        end
    end

    // ---------------- read path ----------------
    logic        w_ar_hs, w_rd_err, w_rvalid_nxt;
    logic [31:0] w_rd_data;

    assign w_ar_hs      = ca4l_arvalid && r_arready;
    assign w_rd_err     = |ca4l_araddr[31:5];
    assign w_rvalid_nxt = r_rvalid ? !ca4l_rready : w_ar_hs;

    always_comb begin
        w_rd_data = '0;
        if (!w_rd_err) begin
            case (reg_sel_e'(ca4l_araddr[4:2]))
                REG_ID:       w_rd_data = ID_VALUE;
                REG_CTRL:     w_rd_data = 32'(r_ctrl);
                REG_STATUS:   w_rd_data = status;
                REG_SCRATCH:  w_rd_data = r_scratch;
                REG_IRQ_PEND: w_rd_data = 32'(r_irq_pend);
                REG_IRQ_EN:   w_rd_data = 32'(r_irq_en);
                REG_TICK:     w_rd_data = r_tick;
                default:      w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
        end
    end

    assign ca4l_awready = r_awready;
    assign ca4l_wready  = r_wready;
    assign ca4l_bvalid  = r_bvalid;
    assign ca4l_bresp   = r_bresp;
    assign ca4l_arready = r_arready;
    assign ca4l_rvalid  = r_rvalid;
    assign ca4l_rdata   = r_rdata;
    assign ca4l_rresp   = r_rresp;
    assign ctrl         = r_ctrl;
    assign irq          = r_irq;

    // Protection bits, byte offsets and the unused upper bits of the merge
    // results carry no function here.
    logic w_unused;
    assign w_unused = ^{ca4l_awprot, ca4l_arprot, w_wr_merged, w_wr_clr};

endmodule

// File: tb/tb_ups_axil_regs.sv
module tb_ups_axil_regs;

    localparam logic [31:0] ID_VALUE = 32'h5550_5301;
    localparam int CTRL_W = 4;
    localparam int EVT_W  = 8;

    logic              fclk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       awaddr = '0, wdata = '0, araddr = '0, status = '0;
    logic [3:0]        wstrb = '0;
    logic              awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [EVT_W-1:0]  evt = '0;
    logic              awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [CTRL_W-1:0] ctrl;

    int total = 0;
    int bad   = 0;
    int unsigned cyc;

    // Reference state
    logic [CTRL_W-1:0] m_ctrl;
    logic [31:0]       m_scratch;
    logic [EVT_W-1:0]  m_pend, m_en;

    ups_axil_regs #(.ID_VALUE(ID_VALUE), .CTRL_W(CTRL_W), .EVT_W(EVT_W)) dut (
        .fclk(fclk), .rst_n(rst_n),
        .ca4l_awaddr(awaddr), .ca4l_awprot(3'b000), .ca4l_awvalid(awvalid), .ca4l_awready(awready),
        .ca4l_wdata(wdata), .ca4l_wstrb(wstrb), .ca4l_wvalid(wvalid), .ca4l_wready(wready),
        .ca4l_bresp(bresp), .ca4l_bvalid(bvalid), .ca4l_bready(bready),
        .ca4l_araddr(araddr), .ca4l_arprot(3'b000), .ca4l_arvalid(arvalid), .ca4l_arready(arready),
        .ca4l_rdata(rdata), .ca4l_rresp(rresp), .ca4l_rvalid(rvalid), .ca4l_rready(rready),
        .status(status), .evt(evt), .ctrl(ctrl), .irq(irq)
    );

    always #5 fclk = ~fclk;

    // Number of clock edges since reset release; equals TICK seen at a negedge.
    always @(posedge fclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void model_reset();
        m_ctrl = '0; m_scratch = '0; m_pend = '0; m_en = '0;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Applies a write to the reference state; returns the expected response.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] m, cur;
        m = byte_mask(s);
        if (a[31:5] != 0) return 2'b10;
        case (a[4:2])
            3'd1: begin cur = 32'(m_ctrl);    cur = (cur & ~m) | (d & m); m_ctrl = cur[CTRL_W-1:0]; end
            3'd3: m_scratch = (m_scratch & ~m) | (d & m);
            3'd4: begin cur = d & m; m_pend = m_pend & ~cur[EVT_W-1:0]; end
            3'd5: begin cur = 32'(m_en);      cur = (cur & ~m) | (d & m); m_en = cur[EVT_W-1:0]; end
            default: ;
        endcase
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int unsigned t,
                                               input logic [31:0] st);
        if (a[31:5] != 0) return 32'h0;
        case (a[4:2])
            3'd0: return ID_VALUE;
            3'd1: return 32'(m_ctrl);
            3'd2: return st;
            3'd3: return m_scratch;
            3'd4: return 32'(m_pend);
            3'd5: return 32'(m_en);
            3'd6: return t;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        bit aw_ok, w_ok, aw_go, w_go;
        @(negedge fclk);
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 50) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge fclk); n++;
            if (aw_go) begin awvalid = 0; aw_ok = 1; end
            if (w_go)  begin wvalid = 0;  w_ok = 1;  end
        end
        n = 0;
        while (!bvalid && n < 50) begin @(negedge fclk); n++; end
        total++;
        if (!bvalid) begin
            bad++;
            $display("FAIL write_timeout: addr %h got no bvalid", a);
        end
        resp = bresp;
        @(negedge fclk);
        bready = 0; awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                            output int lat, output int unsigned hs);
        int n;
        @(negedge fclk);
        araddr = a; arvalid = 1; rready = 1; n = 0;
        while (!arready && n < 50) begin @(negedge fclk); n++; end
        hs = cyc;
        @(negedge fclk);
        arvalid = 0; lat = 1;
        while (!rvalid && lat < 50) begin @(negedge fclk); lat++; end
        total++;
        if (!rvalid) begin
            bad++;
            $display("FAIL read_timeout: addr %h got no rvalid", a);
        end
        d = rdata; r = rresp;
        @(negedge fclk);
        rready = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge fclk);
        total++;
        if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b0 || ctrl !== '0 ||
            rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs: rdy/valid/irq=%b ctrl=%h rdata=%h want all zero",
                     {awready, wready, arready, bvalid, rvalid, irq}, ctrl, rdata);
        end
        rst_n = 1;
        #1;
        total++;
        if ({awready, wready, arready} !== 3'b000) begin
            bad++;
            $display("FAIL ready_before_edge: got %b want 000", {awready, wready, arready});
        end
        @(negedge fclk);
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++;
            $display("FAIL ready_after_edge: got %b want 111", {awready, wready, arready});
        end
    endtask

    task automatic test_id();
        logic [31:0] d; logic [1:0] r; int lat; int unsigned hs;
        for (int k = 0; k < 2; k++) begin
            axi_read((k == 0) ? 32'h0 : 32'h3, d, r, lat, hs);
            total++;
            if (d !== ID_VALUE || r !== 2'b00 || lat != 1) begin
                bad++;
                $display("FAIL id_read: data=%h resp=%b lat=%0d want %h 00 1", d, r, lat, ID_VALUE);
            end
        end
    endtask

    task automatic test_scratch_strb();
        logic [31:0] d; logic [1:0] r, b; int lat; int unsigned hs;
        axi_write(32'h0C, 32'hDEAD_BEEF, 4'hF, b);
        void'(model_write(32'h0C, 32'hDEAD_BEEF, 4'hF));
        axi_write(32'h0C, 32'hA5A5_1234, 4'b0101, b);
        void'(model_write(32'h0C, 32'hA5A5_1234, 4'b0101));
        axi_read(32'h0C, d, r, lat, hs);
        total++;
        if (d !== 32'hDEA5_BE34 || r !== 2'b00 || b !== 2'b00) begin
            bad++;
            $display("FAIL scratch_strb: data=%h resp=%b bresp=%b want DEA5BE34 00 00", d, r, b);
        end
    endtask

    task automatic test_random_rw();
        logic [31:0] a, d, exp_d; logic [1:0] r, exp_r; logic [3:0] s; int lat; int unsigned hs;
        for (int i = 0; i < 60; i++) begin
            a = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
            if ($urandom_range(0, 9) == 0) a[31:5] = 27'($urandom) | 27'd1;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom);
                exp_r = model_write(a, d, s);
                axi_write(a, d, s, r);
                total++;
                if (r !== exp_r || ctrl !== m_ctrl) begin
                    bad++;
                    $display("FAIL rand_write: addr=%h bresp=%b ctrl=%h want %b %h", a, r, ctrl, exp_r, m_ctrl);
                end
            end else begin
                status = $urandom;
                axi_read(a, d, r, lat, hs);
                exp_d = model_read(a, hs, status);
                exp_r = (a[31:5] != 0) ? 2'b10 : 2'b00;
                total++;
                if (d !== exp_d || r !== exp_r || lat != 1) begin
                    bad++;
                    $display("FAIL rand_read: addr=%h data=%h resp=%b lat=%0d want %h %b 1",
                             a, d, r, lat, exp_d, exp_r);
                end
            end
        end
    endtask

    task automatic test_split_write();
        logic [CTRL_W-1:0] old_ctrl;
        logic exp_aw, exp_w, exp_b;
        old_ctrl = m_ctrl;
        @(negedge fclk);
        awaddr = 32'h04; awvalid = 1; wvalid = 0; bready = 0;   // cycle 0
        for (int c = 1; c <= 9; c++) begin
            @(negedge fclk);
            if (c == 1) awvalid = 0;
            exp_aw = (c >= 9);
            exp_w  = (c <= 3) || (c >= 9);
            exp_b  = (c >= 4) && (c <= 8);
            total++;
            if (awready !== exp_aw || wready !== exp_w || bvalid !== exp_b ||
                (exp_b && bresp !== 2'b00) || ctrl !== ((c >= 4) ? 4'hA : old_ctrl)) begin
                bad++;
                $display("FAIL split_write c%0d: aw=%b w=%b b=%b ctrl=%h want %b %b %b %h",
                         c, awready, wready, bvalid, ctrl, exp_aw, exp_w, exp_b,
                         (c >= 4) ? 4'hA : old_ctrl);
            end
            if (c == 3) begin wdata = 32'h0000_000A; wstrb = 4'hF; wvalid = 1; end
            if (c == 4) wvalid = 0;
            if (c == 8) bready = 1;
        end
        bready = 0;
        void'(model_write(32'h04, 32'h0000_000A, 4'hF));
    endtask

    task automatic test_irq();
        logic [31:0] d; logic [1:0] r, b; int lat; int unsigned hs;
        axi_write(32'h10, 32'hFF, 4'hF, b); void'(model_write(32'h10, 32'hFF, 4'hF));
        axi_write(32'h14, 32'h04, 4'hF, b); void'(model_write(32'h14, 32'h04, 4'hF));
        @(negedge fclk); evt = 8'h04;
        @(negedge fclk); evt = 8'h00; m_pend |= 8'h04;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_latency: irq=%b want 0", irq); end
        @(negedge fclk);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: irq=%b want 1", irq); end
        // W1C and evt on the same edge: set wins.
        @(negedge fclk);
        awaddr = 32'h10; awvalid = 1; wdata = 32'h04; wstrb = 4'hF; wvalid = 1; bready = 1; evt = 8'h04;
        @(negedge fclk);
        awvalid = 0; wvalid = 0; evt = 8'h00;
        @(negedge fclk); bready = 0;
        axi_read(32'h10, d, r, lat, hs);
        total++;
        if (d !== 32'h04 || irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set_wins: pend=%h irq=%b want 00000004 1", d, irq);
        end
        axi_write(32'h10, 32'h04, 4'hF, b); void'(model_write(32'h10, 32'h04, 4'hF));
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: irq=%b want 0", irq); end
        // Randomized events, enables and clears.
        for (int i = 0; i < 12; i++) begin
            logic [EVT_W-1:0] e; logic [31:0] v; logic [3:0] s;
            e = EVT_W'($urandom);
            @(negedge fclk); evt = e;
            @(negedge fclk); evt = '0; m_pend |= e;
            v = $urandom; s = 4'($urandom);
            axi_write(($urandom_range(0, 1) == 0) ? 32'h10 : 32'h14, v, s, b);
            void'(model_write(awaddr, v, s));
            axi_read(32'h10, d, r, lat, hs);
            total++;
            if (d !== 32'(m_pend) || irq !== |(m_pend & m_en)) begin
                bad++;
                $display("FAIL irq_rand%0d: pend=%h irq=%b want %h %b", i, d, irq, m_pend, |(m_pend & m_en));
            end
        end
    endtask

    task automatic test_decode_err();
        logic [31:0] d; logic [1:0] r, b; int lat; int unsigned hs;
        axi_read(32'h20, d, r, lat, hs);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++; $display("FAIL read_decerr: data=%h resp=%b want 0 10", d, r);
        end
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, b);
        axi_write(32'h00, 32'h1234_5678, 4'hF, r);
        total++;
        if (b !== 2'b10 || r !== 2'b00) begin
            bad++; $display("FAIL write_decerr: bresp=%b ro_bresp=%b want 10 00", b, r);
        end
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            if (k == 2) continue;
            a = 32'(k) << 2;
            axi_read(a, d, r, lat, hs);
            total++;
            if (d !== model_read(a, hs, status)) begin
                bad++; $display("FAIL regs_unchanged %h: got %h want %h", a, d, model_read(a, hs, status));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old; int cnt;
        old = m_scratch;
        @(negedge fclk);
        awaddr = 32'h0C; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        araddr = 32'h0C; arvalid = 1; rready = 1;
        @(negedge fclk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        total++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== old) begin
            bad++;
            $display("FAIL same_cycle: bvalid=%b rvalid=%b rdata=%h want 1 1 %h", bvalid, rvalid, rdata, old);
        end
        void'(model_write(32'h0C, 32'h1234_5678, 4'hF));
        @(negedge fclk);
        bready = 0;
        araddr = 32'h0; arvalid = 1; cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge fclk);
            if (rvalid) cnt++;
        end
        arvalid = 0;
        @(negedge fclk); rready = 0;
        total++;
        if (cnt != 4) begin bad++; $display("FAIL read_rate: got %0d beats in 8 cycles want 4", cnt); end
    endtask

    task automatic test_tick();
        logic [31:0] d1, d2; logic [1:0] r; int lat; int unsigned h1, h2;
        axi_read(32'h18, d1, r, lat, h1);
        while (cyc < h1 + 9) @(negedge fclk);
        axi_read(32'h18, d2, r, lat, h2);
        total++;
        if (d2 - d1 != 32'd10 || d1 !== 32'(h1)) begin
            bad++; $display("FAIL tick_delta: t1=%h t2=%h want diff 10 and t1=%h", d1, d2, h1);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d; logic [1:0] r; int lat; int unsigned hs;
        @(negedge fclk);
        awaddr = 32'h0C; awvalid = 1;
        @(negedge fclk);
        awvalid = 0; rst_n = 0;
        #1;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b0 || ctrl !== '0) begin
            bad++; $display("FAIL mid_reset: bvalid=%b awready=%b ctrl=%h want 0 0 0", bvalid, awready, ctrl);
        end
        model_reset();
        @(negedge fclk); rst_n = 1;
        @(negedge fclk);
        axi_read(32'h0C, d, r, lat, hs);
        total++;
        if (d !== 32'h0 || bvalid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_regs: scratch=%h bvalid=%b want 0 0", d, bvalid);
        end
    endtask

    task automatic test_tick_wrap();
        logic [31:0] d; logic [1:0] r; int lat; int unsigned hs;
        @(negedge fclk);
        force dut.r_tick = 32'hFFFF_FFFF;
        #1;
        release dut.r_tick;
        axi_read(32'h18, d, r, lat, hs);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL tick_wrap: got %h want 00000000", d); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_id();
        test_scratch_strb();
        test_random_rw();
        test_split_write();
        test_irq();
        test_decode_err();
        test_back_to_back();
        test_tick();
        test_reset_midflight();
        test_tick_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
